rgb_stream_arbiter: RTL and testbench

Round-robin arbiter that shares one RGB pixel output channel between three requesting pixel streams with valid/ready handshakes. A grant is held for a whole line, ending on the requester's `last` beat, or until a configurable burst limit forces rotation. Output is a single registered stage feeding the composite `outp_r/g/b` pixel port used by the top-level video datapath.

---
 rtl/rgb_pkg.sv | 19 +
 rtl/rgb_stream_arbiter_if.sv | 41 ++++
 rtl/rgb_rr_picker.sv | 25 ++
 rtl/rgb_stream_arbiter.sv | 139 +++++++++++++
 tb/tb_rgb_stream_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB stream arbiter.
package rgb_pkg;

  localparam int RGB_DATA_WIDTH = 8;
  localparam int RGB_NUM_REQ    = 3;
  localparam logic [1:0] RGB_GRANT_NONE = 2'd3;

  typedef struct packed {
    logic [RGB_DATA_WIDTH-1:0] r;
    logic [RGB_DATA_WIDTH-1:0] g;
    logic [RGB_DATA_WIDTH-1:0] b;
  } rgb_pixel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } rgb_arb_state_t;

endpackage

// File: rtl/rgb_stream_arbiter_if.sv
// Three requesting pixel streams, the shared output pixel port and arbiter status.
interface rgb_stream_arbiter_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  in0_valid, in0_ready, in0_last;
  logic [DATA_WIDTH-1:0] in0_r, in0_g, in0_b;
  logic                  in1_valid, in1_ready, in1_last;
  logic [DATA_WIDTH-1:0] in1_r, in1_g, in1_b;
  logic                  in2_valid, in2_ready, in2_last;
  logic [DATA_WIDTH-1:0] in2_r, in2_g, in2_b;

  logic                  outp_valid, outp_ready, outp_last;
  logic [DATA_WIDTH-1:0] outp_r, outp_g, outp_b;

  logic [1:0]            grant;
  logic                  idle;

  // Environment side: drives requesters and downstream ready.
  modport master (
    output in0_valid, in0_last, in0_r, in0_g, in0_b,
    output in1_valid, in1_last, in1_r, in1_g, in1_b,
    output in2_valid, in2_last, in2_r, in2_g, in2_b,
    input  in0_ready, in1_ready, in2_ready,
    input  outp_valid, outp_last, outp_r, outp_g, outp_b,
    output outp_ready,
    input  grant, idle
  );

  // Arbiter side.
  modport slave (
    input  in0_valid, in0_last, in0_r, in0_g, in0_b,
    input  in1_valid, in1_last, in1_r, in1_g, in1_b,
    input  in2_valid, in2_last, in2_r, in2_g, in2_b,
    output in0_ready, in1_ready, in2_ready,
    output outp_valid, outp_last, outp_r, outp_g, outp_b,
    input  outp_ready,
    output grant, idle
  );

endinterface

// File: rtl/rgb_rr_picker.sv
// Combinational round-robin pick: first valid requester after prev, prev itself last.
module rgb_rr_picker
  import rgb_pkg::*;
(
  input  logic [RGB_NUM_REQ-1:0] valid_i,
  input  logic [1:0]             prev_i,
  output logic [1:0]             winner_o,
  output logic                   any_o
);

  logic [1:0] sel;

  // Scan from lowest to highest priority so the highest-priority valid wins last.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    winner_o = 2'd0;
    sel      = 2'd0;
    any_o    = |valid_i;
    for (int off = RGB_NUM_REQ; off >= 1; off--) begin
      sel = 2'((int'(prev_i) + off) % RGB_NUM_REQ);
      if (valid_i[sel]) winner_o = sel;
    end
  end

endmodule

// File: rtl/rgb_stream_arbiter.sv
// Line-locked round-robin arbiter of three RGB pixel streams onto one registered output.
module rgb_stream_arbiter
  import rgb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input logic                 clk,
  input logic                 rst,
  rgb_stream_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] g;
    logic [DATA_WIDTH-1:0] b;
  } pix_t;

  rgb_arb_state_t   state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic             outp_valid_q, outp_last_q;
  pix_t             outp_pix_q;

  logic [2:0]       in_valid, in_last;
  pix_t             in_pix [3];
  logic             owner_valid, owner_last;
  pix_t             owner_pix;
  logic             can_accept, accept, end_line;
  logic [1:0]       pick_winner;
  logic             pick_any;

  assign in_valid  = {bus.in2_valid, bus.in1_valid, bus.in0_valid};
  assign in_last   = {bus.in2_last, bus.in1_last, bus.in0_last};
  assign in_pix[0] = {bus.in0_r, bus.in0_g, bus.in0_b};
  assign in_pix[1] = {bus.in1_r, bus.in1_g, bus.in1_b};
  assign in_pix[2] = {bus.in2_r, bus.in2_g, bus.in2_b};

  rgb_rr_picker u_picker (
    .valid_i  (in_valid),
    .prev_i   (prev_q),
    .winner_o (pick_winner),
    .any_o    (pick_any)
  );

  // Select the current owner's beat; nothing is selected while no grant is held.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_pix   = '0;
    case (grant_q)
      2'd0: begin owner_valid = in_valid[0]; owner_last = in_last[0]; owner_pix = in_pix[0]; end
      2'd1: begin owner_valid = in_valid[1]; owner_last = in_last[1]; owner_pix = in_pix[1]; end
      2'd2: begin owner_valid = in_valid[2]; owner_last = in_last[2]; owner_pix = in_pix[2]; end
      default: ;
    endcase
  end

  // Owner may transfer whenever the output register is empty or being drained this cycle.
  assign can_accept = (state_q == LOCKED) && (!outp_valid_q || bus.outp_ready);
  assign accept     = can_accept && owner_valid;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign end_line   = accept && (owner_last || (cnt_inc == CNT_W'(MAX_BURST)));

  assign bus.in0_ready = can_accept && (grant_q == 2'd0);
  assign bus.in1_ready = can_accept && (grant_q == 2'd1);
  assign bus.in2_ready = can_accept && (grant_q == 2'd2);

  // Next-state logic: grant in IDLE, count beats and release on last or burst limit in LOCKED.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_winner;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (accept) cnt_d = cnt_inc;
        if (end_line) begin
          state_d = IDLE;
          prev_d  = grant_q;
          grant_d = RGB_GRANT_NONE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= RGB_GRANT_NONE;
      prev_q  <= 2'd2;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      grant_q <= grant_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output stage: load on accept, drop valid once consumed, data holds its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: data fields are reset too, so a discarded pixel never shows after reset.
      outp_valid_q <= 1'b0;
      outp_last_q  <= 1'b0;
      outp_pix_q   <= '0;
    end else if (accept) begin
      outp_valid_q <= 1'b1;
      outp_last_q  <= owner_last;
      outp_pix_q   <= owner_pix;
    end else if (bus.outp_ready) begin
      outp_valid_q <= 1'b0;
    end
  end

  assign bus.outp_valid = outp_valid_q;
  assign bus.outp_last  = outp_last_q;
  assign bus.outp_r     = outp_pix_q.r;
  assign bus.outp_g     = outp_pix_q.g;
  assign bus.outp_b     = outp_pix_q.b;
  assign bus.grant      = grant_q;
  assign bus.idle       = (state_q == IDLE);

endmodule

// File: tb/tb_rgb_stream_arbiter.sv
// Scoreboard bench for rgb_stream_arbiter: directed streams, queued expected beats, negedge monitor.
module tb_rgb_stream_arbiter;
  import rgb_pkg::*;

  localparam int DW = 8;
  localparam int MB = 4;

  typedef struct packed {
    rgb_pixel_t pix;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic outp_ready = 1'b1;

  always #5 clk = ~clk;

  rgb_stream_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  rgb_stream_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t      drv [3];
  logic [2:0] drv_valid;
  logic [2:0] drv_fire;

  assign bus.in0_valid = drv_valid[0];
  assign bus.in0_r     = drv[0].pix.r;
  assign bus.in0_g     = drv[0].pix.g;
  assign bus.in0_b     = drv[0].pix.b;
  assign bus.in0_last  = drv[0].last;
  assign bus.in1_valid = drv_valid[1];
  assign bus.in1_r     = drv[1].pix.r;
  assign bus.in1_g     = drv[1].pix.g;
  assign bus.in1_b     = drv[1].pix.b;
  assign bus.in1_last  = drv[1].last;
  assign bus.in2_valid = drv_valid[2];
  assign bus.in2_r     = drv[2].pix.r;
  assign bus.in2_g     = drv[2].pix.g;
  assign bus.in2_b     = drv[2].pix.b;
  assign bus.in2_last  = drv[2].last;
  assign bus.outp_ready = outp_ready;

  beat_t src0[$], src1[$], src2[$], exp_q[$];
  beat_t mon_exp;
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] last_popped = 8'h00;
  int wait_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Requester n, beat k: r = n*64+k, g = ~r, b = r+1.
  function automatic beat_t px(input int n, input int k, input logic last);
    beat_t b;
    logic [7:0] r;
    r = 8'(n * 64 + k);
    b.pix.r = r;
    b.pix.g = ~r;
    b.pix.b = r + 8'd1;
    b.last  = last;
    return b;
  endfunction

  function automatic beat_t mk(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic last);
    beat_t x;
    x.pix.r = r;
    x.pix.g = g;
    x.pix.b = b;
    x.last  = last;
    return x;
  endfunction

  task automatic src_push(input int n, input beat_t b);
    case (n)
      0: src0.push_back(b);
      1: src1.push_back(b);
      default: src2.push_back(b);
    endcase
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((src0.size() + src1.size() + src2.size() + exp_q.size()) != 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_drained"}, 32'(cyc < 500), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Requester drivers: sample handshakes at negedge, advance the queues just after posedge.
  initial begin
    drv_valid = '0;
    drv_fire  = '0;
    for (int n = 0; n < 3; n++) drv[n] = '0;
    forever begin
      @(negedge clk);
      drv_fire = drv_valid & {bus.in2_ready, bus.in1_ready, bus.in0_ready};
      @(posedge clk);
      #1;
      if (drv_fire[0] && src0.size() > 0) void'(src0.pop_front());
      if (drv_fire[1] && src1.size() > 0) void'(src1.pop_front());
      if (drv_fire[2] && src2.size() > 0) void'(src2.pop_front());
      drv_valid[0] = (src0.size() > 0);
      drv_valid[1] = (src1.size() > 0);
      drv_valid[2] = (src2.size() > 0);
      if (src0.size() > 0) drv[0] = src0[0];
      if (src1.size() > 0) drv[1] = src1[0];
      if (src2.size() > 0) drv[2] = src2[0];
    end
  end

  // Monitor: every output transfer is compared against the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.outp_valid && bus.outp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got r=0x%0h with no beat expected at %0t", bus.outp_r, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          check("beat", 32'({bus.outp_r, bus.outp_g, bus.outp_b, bus.outp_last}),
                32'({mon_exp.pix, mon_exp.last}));
          last_popped = bus.outp_r;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held, then released with no requests.
    rst = 1'b0;
    outp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_grant", 32'(bus.grant), 32'd3);
      check("rst_idle", 32'(bus.idle), 32'd1);
      check("rst_outp_valid", 32'(bus.outp_valid), 32'd0);
      check("rst_outp_rgb", 32'({bus.outp_r, bus.outp_g, bus.outp_b}), 32'd0);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_grant", 32'(bus.grant), 32'd3);
      check("idle_idle", 32'(bus.idle), 32'd1);
      check("idle_outp_valid", 32'(bus.outp_valid), 32'd0);
      check("idle_outp_rgb", 32'({bus.outp_r, bus.outp_g, bus.outp_b}), 32'd0);
    end

    // Fairness: all three continuously valid with 2-beat lines -> grant 0,1,2,0,1,2.
    for (int l = 0; l < 2; l++)
      for (int n = 0; n < 3; n++)
        for (int k = 2 * l + 1; k <= 2 * l + 2; k++) begin
          src_push(n, px(n, k, (k % 2) == 0));
          exp_q.push_back(px(n, k, (k % 2) == 0));
        end
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check($sformatf("fair_grant_c%0d", i), 32'(bus.grant),
            (i % 3 == 0) ? 32'd3 : 32'((i / 3) % 3));
    end
    wait_drain("fair");

    // Single line from in0: 4 beats, last on the fourth.
    for (int k = 0; k < 4; k++) begin
      src_push(0, mk(8'h10 + 8'(k), 8'h11, 8'h12, k == 3));
      exp_q.push_back(mk(8'h10 + 8'(k), 8'h11, 8'h12, k == 3));
    end
    @(negedge clk);
    check("line_bubble_grant", 32'(bus.grant), 32'd3);
    @(negedge clk);
    check("line_grant", 32'(bus.grant), 32'd0);
    check("line_in0_ready", 32'(bus.in0_ready), 32'd1);
    wait_drain("line");
    check("line_end_idle", 32'(bus.idle), 32'd1);
    check("line_end_grant", 32'(bus.grant), 32'd3);

    // Forced rotation (burst 4): in1 sends 14 beats, last only on 14; in2 has a 2-beat line.
    for (int k = 1; k <= 14; k++) src_push(1, px(1, k, k == 14));
    for (int k = 1; k <= 2; k++) src_push(2, px(2, k, k == 2));
    for (int k = 1; k <= 4; k++) exp_q.push_back(px(1, k, 1'b0));
    for (int k = 1; k <= 2; k++) exp_q.push_back(px(2, k, k == 2));
    for (int k = 5; k <= 14; k++) exp_q.push_back(px(1, k, k == 14));

    // Backpressure: once beat 11 leaves, stall the output for 3 cycles while beat 12 is held.
    wait_cyc = 0;
    do begin
      @(posedge clk);
      wait_cyc++;
    end while (last_popped != 8'h4B && wait_cyc < 300);
    check("bp_reached_beat11", 32'(wait_cyc < 300), 32'd1);
    #1 outp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_valid_c%0d", i), 32'(bus.outp_valid), 32'd1);
      check($sformatf("bp_hold_rg_c%0d", i), 32'({bus.outp_r, bus.outp_g}), 32'h4CB3);
      check($sformatf("bp_in1_ready_c%0d", i), 32'(bus.in1_ready), 32'd0);
    end
    @(posedge clk);
    #1 outp_ready = 1'b1;
    wait_drain("rotate");
    check("rotate_end_idle", 32'(bus.idle), 32'd1);

    // Mid-line reset while beat 2 of in2 sits in the output register.
    for (int k = 1; k <= 3; k++) begin
      src_push(2, px(2, k, k == 3));
      exp_q.push_back(px(2, k, k == 3));
    end
    wait_cyc = 0;
    do begin
      @(posedge clk);
      wait_cyc++;
    end while (last_popped != 8'h81 && wait_cyc < 300);
    check("mr_reached_beat1", 32'(wait_cyc < 300), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mr_outp_valid", 32'(bus.outp_valid), 32'd0);
    check("mr_outp_rgb", 32'({bus.outp_r, bus.outp_g, bus.outp_b}), 32'd0);
    check("mr_outp_last", 32'(bus.outp_last), 32'd0);
    check("mr_grant", 32'(bus.grant), 32'd3);
    check("mr_idle", 32'(bus.idle), 32'd1);
    check("mr_in2_ready", 32'(bus.in2_ready), 32'd0);
    src0.delete();
    src1.delete();
    src2.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    src_push(0, px(0, 20, 1'b1));
    src_push(2, px(2, 20, 1'b1));
    exp_q.push_back(px(0, 20, 1'b1));
    exp_q.push_back(px(2, 20, 1'b1));
    @(negedge clk);
    check("post_rst_bubble", 32'(bus.grant), 32'd3);
    @(negedge clk);
    check("post_rst_grant", 32'(bus.grant), 32'd0);
    wait_drain("post_rst");
    check("final_idle", 32'(bus.idle), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
